// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
// Floor masks are carried at a fixed maximum width (MAX_FLOORS) so the
// helpers can live in a non-parameterised package; callers zero-extend.
package elevator_pkg;

    localparam int MAX_FLOORS = 64;

    typedef logic [MAX_FLOORS-1:0] floor_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR
    } state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_e;

    // True when any mask bit strictly above at_floor is set.
    function automatic logic any_above(input floor_mask_t mask, input int at_floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i > at_floor && mask[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // True when any mask bit strictly below at_floor is set.
    function automatic logic any_below(input floor_mask_t mask, input int at_floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i < at_floor && mask[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic dir_e flip_dir(input dir_e d);
        return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
    endfunction

    // The bottom floor can only be left upwards, the top only downwards.
    function automatic dir_e bound_dir(input dir_e d, input int at_floor, input int top_floor);
        if (at_floor == 0) return DIR_UP;
        if (at_floor == top_floor) return DIR_DOWN;
        return d;
    endfunction

endpackage

// File: rtl/elevator_request_bank.sv
// Latched request storage: car buttons plus hall UP/DOWN calls.
// A request stays set until the controller clears it; a clear wins over a
// button press in the same cycle, so a door standing open at a floor
// swallows new presses for that floor. Hall bits that have no meaning
// (UP at the top floor, DOWN at floor 0) are held at zero.
module elevator_request_bank #(
    parameter int NUM_FLOORS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_up,
    input  logic [NUM_FLOORS-1:0] call_down,
    input  logic [NUM_FLOORS-1:0] car_select,
    input  logic [NUM_FLOORS-1:0] clr_car,
    input  logic [NUM_FLOORS-1:0] clr_up,
    input  logic [NUM_FLOORS-1:0] clr_down,
    output logic [NUM_FLOORS-1:0] car_req,
    output logic [NUM_FLOORS-1:0] up_req,
    output logic [NUM_FLOORS-1:0] down_req,
    output logic [NUM_FLOORS-1:0] req_pending
);

    localparam logic [NUM_FLOORS-1:0] UP_VALID   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DOWN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    logic [NUM_FLOORS-1:0] car_q,  car_d;
    logic [NUM_FLOORS-1:0] up_q,   up_d;
    logic [NUM_FLOORS-1:0] down_q, down_d;

    // Set on any press, clear on service, mask the meaningless hall bits.
    always_comb begin
        car_d  = (car_q  | car_select) & ~clr_car;
        up_d   = (up_q   | call_up)    & ~clr_up   & UP_VALID;
        down_d = (down_q | call_down)  & ~clr_down & DOWN_VALID;
    end

    // Request registers, emptied by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            car_q  <= '0;
            up_q   <= '0;
            down_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            car_q  <= car_d;
            up_q   <= up_d;
            down_q <= down_d;
        end
    end

    assign car_req     = car_q;
    assign up_req      = up_q;
    assign down_req    = down_q;
    assign req_pending = car_q | up_q | down_q;

endmodule

// File: rtl/elevator_scan_controller.sv
// Parametrised N-floor elevator controller with a SCAN (collective) policy.
// The car keeps moving in its current direction while requests lie ahead,
// stops for car selections and hall calls that match its direction, and
// reverses only when nothing is left ahead. Travel and door dwell are timed
// by a shared down-counter.
// Optional feature macro: ELEV_DOOR_REOPEN_EN adds door_obstruct, which
// holds the door open (timer reloaded) while it is high.
module elevator_scan_controller
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS    = 8,
    parameter  int TRAVEL_CYCLES = 16,
    parameter  int DOOR_CYCLES   = 32,
    localparam int FLOOR_W       = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_up,
    input  logic [NUM_FLOORS-1:0] call_down,
    input  logic [NUM_FLOORS-1:0] car_select,
`ifdef ELEV_DOOR_REOPEN_EN
    input  logic                  door_obstruct,
`endif
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  door_open,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic [NUM_FLOORS-1:0] req_pending
);

    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
    localparam int                 TOP_FLOOR   = NUM_FLOORS - 1;

    state_e               state_q, state_d;
    dir_e                 dir_q,   dir_d;
    logic [FLOOR_W-1:0]   floor_q, floor_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;

    logic [NUM_FLOORS-1:0] car_req, up_req, down_req, pending;
    logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_down;
    floor_mask_t           pend_ext;

    // Decision terms evaluated at the floor the car is at (IDLE) or is
    // about to reach (last travel cycle).
    logic [FLOOR_W-1:0] tgt_floor;
    dir_e               base_dir, fdir, door_dir;
    logic               above_tgt, below_tgt;
    logic               car_here, up_here, down_here;
    logic               ahead_f, behind_f, match_f, opp_f;
    logic               ahead_m, match_m;
    logic               serve_here, stop_here;
    logic               door_hold;

`ifdef ELEV_DOOR_REOPEN_EN
    assign door_hold = door_obstruct;
`else
    assign door_hold = 1'b0;
`endif

    elevator_request_bank #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_req_bank (
        .clk         (clk),
        .rst         (rst),
        .call_up     (call_up),
        .call_down   (call_down),
        .car_select  (car_select),
        .clr_car     (clr_car),
        .clr_up      (clr_up),
        .clr_down    (clr_down),
        .car_req     (car_req),
        .up_req      (up_req),
        .down_req    (down_req),
        .req_pending (pending)
    );

    // Widen the pending mask to the helper-function width.
    always_comb begin
        pend_ext                 = '0;
        pend_ext[NUM_FLOORS-1:0] = pending;
    end

    // Evaluate the request picture at the floor of interest.
    always_comb begin
        tgt_floor = floor_q;
        base_dir  = dir_q;
        if (state_q == MOVE_UP) begin
            tgt_floor = floor_q + FLOOR_W'(1);
            base_dir  = DIR_UP;
        end else if (state_q == MOVE_DOWN) begin
            tgt_floor = floor_q - FLOOR_W'(1);
            base_dir  = DIR_DOWN;
        end

        above_tgt = any_above(pend_ext, int'(tgt_floor));
        below_tgt = any_below(pend_ext, int'(tgt_floor));
        car_here  = car_req[tgt_floor];
        up_here   = up_req[tgt_floor];
        down_here = down_req[tgt_floor];

        // Stop test while travelling uses the motion direction itself.
        ahead_m   = (base_dir == DIR_UP) ? above_tgt : below_tgt;
        match_m   = (base_dir == DIR_UP) ? up_here   : down_here;
        stop_here = car_here | match_m | ~ahead_m;

        // Service decisions use the direction clamped at the end floors.
        fdir     = bound_dir(base_dir, int'(tgt_floor), TOP_FLOOR);
        ahead_f  = (fdir == DIR_UP) ? above_tgt : below_tgt;
        behind_f = (fdir == DIR_UP) ? below_tgt : above_tgt;
        match_f  = (fdir == DIR_UP) ? up_here   : down_here;
        opp_f    = (fdir == DIR_UP) ? down_here : up_here;

        // An opposite hall call is only worth a stop when nothing lies
        // ahead; otherwise IDLE would reopen the door for it forever.
        serve_here = car_here | match_f | (opp_f & ~ahead_f);
        door_dir   = (~ahead_f & ~car_here & ~match_f & opp_f) ? flip_dir(fdir) : fdir;
    end

    // Next-state, direction, floor and timer logic.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d = state_q;
        dir_d   = dir_q;
        floor_d = floor_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (serve_here) begin
                    state_d = DOOR;
                    dir_d   = door_dir;
                    cnt_d   = DOOR_LOAD;
                end else if (ahead_f) begin
                    dir_d   = fdir;
                    state_d = (fdir == DIR_UP) ? MOVE_UP : MOVE_DOWN;
                    cnt_d   = TRAVEL_LOAD;
                end else if (behind_f) begin
                    dir_d   = flip_dir(fdir);
                    state_d = (fdir == DIR_UP) ? MOVE_DOWN : MOVE_UP;
                    cnt_d   = TRAVEL_LOAD;
                end else begin
                    dir_d   = fdir;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (cnt_q == '0) begin
                    floor_d = tgt_floor;
                    if (stop_here) begin
                        state_d = DOOR;
                        dir_d   = door_dir;
                        cnt_d   = DOOR_LOAD;
                    end else begin
                        cnt_d   = TRAVEL_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DOOR: begin
                if (door_hold) begin
                    cnt_d = DOOR_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // While the door is (or is becoming) open, service this floor's
    // car request and the hall call matching the travel direction.
    always_comb begin
        clr_car  = '0;
        clr_up   = '0;
        clr_down = '0;
        if (state_d == DOOR) begin
            clr_car[floor_d] = 1'b1;
            if (dir_d == DIR_UP) clr_up[floor_d]   = 1'b1;
            else                 clr_down[floor_d] = 1'b1;
        end
    end

    // Controller state registers; reset parks the car at floor 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            floor_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            floor_q <= floor_d;
            cnt_q   <= cnt_d;
        end
    end

    assign current_floor = floor_q;
    assign door_open     = (state_q == DOOR);
    assign moving_up     = (state_q == MOVE_UP);
    assign moving_down   = (state_q == MOVE_DOWN);
    assign req_pending   = pending;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Self-checking bench for elevator_scan_controller (4 floors, 4-cycle
// travel, 6-cycle door). A behavioural model tracks the car as a floor
// number, a heading flag and a phase with a remaining-cycle count, and
// every cycle all outputs are compared with it. Directed scenarios add
// fixed expectations on door length, travel timing and stop order.
module tb_elevator_scan_controller;

    localparam int NF = 4;
    localparam int TC = 4;
    localparam int DC = 6;

    localparam int PH_IDLE   = 0;
    localparam int PH_TRAVEL = 1;
    localparam int PH_DOOR   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] call_up;
    logic [NF-1:0] call_down;
    logic [NF-1:0] car_select;
    logic          door_obstruct;
    logic [1:0]    current_floor;
    logic          door_open;
    logic          moving_up;
    logic          moving_down;
    logic [NF-1:0] req_pending;

    elevator_scan_controller #(
        .NUM_FLOORS    (NF),
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .call_up       (call_up),
        .call_down     (call_down),
        .car_select    (car_select),
`ifdef ELEV_DOOR_REOPEN_EN
        .door_obstruct (door_obstruct),
`endif
        .current_floor (current_floor),
        .door_open     (door_open),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .req_pending   (req_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_floor;
    bit m_up;
    int m_phase;
    int m_left;
    bit m_car [NF];
    bit m_hu  [NF];
    bit m_hd  [NF];

    function automatic void model_reset();
        m_floor = 0;
        m_up    = 1'b1;
        m_phase = PH_IDLE;
        m_left  = 0;
        for (int i = 0; i < NF; i++) begin
            m_car[i] = 1'b0;
            m_hu[i]  = 1'b0;
            m_hd[i]  = 1'b0;
        end
    endfunction

    function automatic bit m_beyond(input int f, input bit up);
        for (int i = 0; i < NF; i++) begin
            if ((up ? (i > f) : (i < f)) && (m_car[i] || m_hu[i] || m_hd[i])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_forced(input int f, input bit up);
        if (f == 0) return 1'b1;
        if (f == NF - 1) return 1'b0;
        return up;
    endfunction

    function automatic bit m_hall(input int f, input bit up);
        return up ? m_hu[f] : m_hd[f];
    endfunction

    function automatic void m_open_door(input int f, input bit up);
        bit d;
        d = m_forced(f, up);
        if (!m_beyond(f, d) && !m_car[f] && !m_hall(f, d) && m_hall(f, !d)) d = !d;
        m_up    = d;
        m_phase = PH_DOOR;
        m_left  = DC;
    endfunction

    function automatic void model_step(input logic [NF-1:0] cu, input logic [NF-1:0] cd,
                                       input logic [NF-1:0] cs, input bit obs);
        bit d;
        case (m_phase)
            PH_IDLE: begin
                d = m_forced(m_floor, m_up);
                if (m_car[m_floor] || m_hall(m_floor, d) ||
                    (m_hall(m_floor, !d) && !m_beyond(m_floor, d))) begin
                    m_open_door(m_floor, d);
                end else if (m_beyond(m_floor, d)) begin
                    m_up = d; m_phase = PH_TRAVEL; m_left = TC;
                end else if (m_beyond(m_floor, !d)) begin
                    m_up = !d; m_phase = PH_TRAVEL; m_left = TC;
                end else begin
                    m_up = d;
                end
            end
            PH_TRAVEL: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    if (m_car[m_floor] || m_hall(m_floor, m_up) || !m_beyond(m_floor, m_up))
                        m_open_door(m_floor, m_up);
                    else
                        m_left = TC;
                end
            end
            default: begin
                if (obs) m_left = DC;
                else begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_IDLE;
                end
            end
        endcase
        for (int i = 0; i < NF; i++) begin
            if (cs[i]) m_car[i] = 1'b1;
            if (cu[i] && i != NF - 1) m_hu[i] = 1'b1;
            if (cd[i] && i != 0) m_hd[i] = 1'b1;
        end
        if (m_phase == PH_DOOR) begin
            m_car[m_floor] = 1'b0;
            if (m_up) m_hu[m_floor] = 1'b0;
            else      m_hd[m_floor] = 1'b0;
        end
    endfunction

    task automatic compare_all(input string tag);
        logic [NF-1:0] exp_pend;
        for (int i = 0; i < NF; i++) exp_pend[i] = m_car[i] | m_hu[i] | m_hd[i];
        check({tag, ".floor"}, 32'(current_floor), 32'(m_floor));
        check({tag, ".door"},  32'(door_open),   32'(m_phase == PH_DOOR));
        check({tag, ".up"},    32'(moving_up),   32'(m_phase == PH_TRAVEL && m_up));
        check({tag, ".down"},  32'(moving_down), 32'(m_phase == PH_TRAVEL && !m_up));
        check({tag, ".pend"},  32'(req_pending), 32'(exp_pend));
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare
    // at the next falling edge.
    task automatic tick(input logic [NF-1:0] cu, input logic [NF-1:0] cd,
                        input logic [NF-1:0] cs, input bit obs);
        call_up       = cu;
        call_down     = cd;
        car_select    = cs;
        door_obstruct = obs;
        @(posedge clk);
        model_step(cu, cd, cs, obs);
        @(negedge clk);
        compare_all("cyc");
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        call_up = '0; call_down = '0; car_select = '0; door_obstruct = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        compare_all("rst");
        check("rst_floor0", 32'(current_floor), 32'd0);
        check("rst_pend0",  32'(req_pending),   32'd0);
        @(posedge clk);
        @(negedge clk);
        compare_all("rst_hold");
        rst = 1'b1;
    endtask

    int door_cnt, up_cnt, first_mu, first_f1, door_floor;
    bit motor_seen, prev_door;
    int stops[$];

    initial begin
        rst = 1'b0;
        call_up = '0; call_down = '0; car_select = '0; door_obstruct = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Call at the current floor: door only, exactly DC cycles.
        tick('0, '0, 4'b0001, 1'b0);
        door_cnt = 0; motor_seen = 1'b0;
        repeat (20) begin
            tick('0, '0, '0, 1'b0);
            if (door_open) door_cnt++;
            if (moving_up || moving_down) motor_seen = 1'b1;
        end
        check("t1_door_len", 32'(door_cnt), 32'd6);
        check("t1_no_motor", 32'(motor_seen), 32'd0);
        check("t1_pend", 32'(req_pending), 32'd0);

        // Floor 0 to floor 3.
        tick('0, '0, 4'b1000, 1'b0);
        up_cnt = 0; first_mu = -1; first_f1 = -1; door_floor = -1;
        for (int i = 0; i < 40; i++) begin
            tick('0, '0, '0, 1'b0);
            if (moving_up) up_cnt++;
            if (moving_up && first_mu < 0) first_mu = i;
            if (current_floor == 2'd1 && first_f1 < 0) first_f1 = i;
            if (door_open && door_floor < 0) door_floor = int'(current_floor);
        end
        check("t2_up_len", 32'(up_cnt), 32'd12);
        check("t2_floor1_delay", 32'(first_f1 - first_mu), 32'd4);
        check("t2_door_floor", 32'(door_floor), 32'd3);

        // Meaningless hall buttons are dropped.
        tick(4'b1000, 4'b0001, '0, 1'b0);
        tick('0, '0, '0, 1'b0);
        check("ign_pend", 32'(req_pending), 32'd0);
        check("ign_idle", 32'({door_open, moving_up, moving_down}), 32'd0);

        // Collective stops: 0->3 with down@1 and up@2 registered en route.
        do_reset();
        tick('0, '0, 4'b1000, 1'b0);
        tick('0, '0, '0, 1'b0);
        tick('0, '0, '0, 1'b0);
        tick(4'b0100, 4'b0010, '0, 1'b0);
        prev_door = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick('0, '0, '0, 1'b0);
            if (door_open && !prev_door) stops.push_back(int'(current_floor));
            prev_door = door_open;
        end
        check("t3_nstops", 32'(stops.size()), 32'd3);
        if (stops.size() == 3) begin
            check("t3_stop0", 32'(stops[0]), 32'd2);
            check("t3_stop1", 32'(stops[1]), 32'd3);
            check("t3_stop2", 32'(stops[2]), 32'd1);
        end

        // Reset in the middle of a 1->2 trip.
        tick('0, '0, 4'b1100, 1'b0);
        tick('0, '0, '0, 1'b0);
        tick('0, '0, '0, 1'b0);
        check("t5_moving", 32'({moving_up, current_floor}), 32'({1'b1, 2'd1}));
        do_reset();

        // Randomised traffic.
        for (int n = 0; n < 2500; n++) begin
            logic [NF-1:0] cu, cd, cs;
            bit ob;
            cu = ($urandom_range(0, 9) == 0) ? NF'(1 << $urandom_range(0, NF - 1)) : '0;
            cd = ($urandom_range(0, 9) == 0) ? NF'(1 << $urandom_range(0, NF - 1)) : '0;
            cs = ($urandom_range(0, 7) == 0) ? NF'(1 << $urandom_range(0, NF - 1)) : '0;
            ob = 1'b0;
`ifdef ELEV_DOOR_REOPEN_EN
            ob = ($urandom_range(0, 29) == 0);
`endif
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick(cu, cd, cs, ob);
        end

`ifdef ELEV_DOOR_REOPEN_EN
        // Obstruction during door cycles 4..13 of the open period.
        for (int i = 0; i < 300; i++) begin
            if (!door_open && !moving_up && !moving_down && req_pending == '0) break;
            tick('0, '0, '0, 1'b0);
        end
        tick('0, '0, NF'(1 << current_floor), 1'b0);
        door_cnt = 0;
        for (int j = 0; j < 60; j++) begin
            tick('0, '0, '0, (j >= 4 && j <= 13));
            if (door_open) door_cnt++;
        end
        check("obs_door_len", 32'(door_cnt), 32'd19);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
